// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: forward-select codes,
// mul/div sequencer state encoding and default latencies.
package pipeline_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam int unsigned MUL_CYCLES_DEF = 4;
   localparam int unsigned DIV_CYCLES_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } md_state_e;

   // Pick the newest in-flight producer of a source register.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] src,
      input logic [4:0] mem_rd,
      input logic       mem_we,
      input logic [4:0] wb_rd,
      input logic       wb_we
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_we && (mem_rd != 5'd0) && (mem_rd == src))
         sel = FWD_MEM;
      else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/ex_hazard_ctrl_forward_unit.sv
// Combinational operand forwarding selects for the EX muxes.
// EX/MEM wins over MEM/WB; r0 is never forwarded.
module forward_unit
   import pipeline_pkg::*;
(
   input  logic [4:0] ex_rs_i,
   input  logic [4:0] ex_rt_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_we_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_we_i,
   output logic [1:0] fwd_a_o,
   output logic [1:0] fwd_b_o
);

   // Select source for each EX operand.
   always_comb begin
      fwd_a_o = fwd_sel(ex_rs_i, mem_rd_i, mem_we_i,
                        wb_rd_i, wb_we_i);
      fwd_b_o = fwd_sel(ex_rt_i, mem_rd_i, mem_we_i,
                        wb_rd_i, wb_we_i);
   end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: forwarding, load-use stall,
// branch flush and multi-cycle mul/div sequencing.
module ex_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       ex_mem_read,
   input  logic       ex_muldiv_start,
   input  logic       ex_muldiv_is_div,
   input  logic [4:0] mem_rd,
   input  logic       mem_reg_write,
   input  logic [4:0] wb_rd,
   input  logic       wb_reg_write,
   input  logic       branch_taken,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b,
   output logic       stall_pc,
   output logic       stall_ifid,
   output logic       stall_idex,
   output logic       flush_ifid,
   output logic       flush_idex,
   output logic       flush_exmem,
   output logic       muldiv_busy,
   output logic       hilo_write,
   output logic [5:0] muldiv_cnt
);

   localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

   md_state_e  state_q;
   logic [5:0] cnt_q;
   logic [1:0] fa;
   logic [1:0] fb;
   logic       lu;
   logic       md_stall;

   forward_unit u_fwd (
      .ex_rs_i  (ex_rs),
      .ex_rt_i  (ex_rt),
      .mem_rd_i (mem_rd),
      .mem_we_i (mem_reg_write),
      .wb_rd_i  (wb_rd),
      .wb_we_i  (wb_reg_write),
      .fwd_a_o  (fa),
      .fwd_b_o  (fb)
   );

   // Load in EX whose target feeds the instruction in ID.
   always_comb begin
      lu = ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
   end

   // Front end frozen on the start cycle and through BUSY.
   always_comb begin
      md_stall = (state_q == BUSY) ||
                 ((state_q == IDLE) && ex_muldiv_start);
   end

   // Mul/div sequencer; a taken branch squashes the op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ex_muldiv_start && !branch_taken) begin
                  state_q <= BUSY;
                  cnt_q   <= ex_muldiv_is_div ? DIV_LOAD
                                              : MUL_LOAD;
               end
            end
            BUSY: begin
               if (branch_taken) begin
                  state_q <= IDLE;
                  cnt_q   <= 6'd0;
               end else if (cnt_q == 6'd1) begin
                  state_q <= DONE;
                  cnt_q   <= 6'd0;
               end else begin
                  cnt_q <= cnt_q - 6'd1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               cnt_q   <= 6'd0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 6'd0;
            end
         endcase
      end
   end

   // Prioritised stall/flush outputs, all quiet in reset.
   always_comb begin
      forward_a   = FWD_RF;
      forward_b   = FWD_RF;
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      stall_idex  = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      muldiv_busy = 1'b0;
      hilo_write  = 1'b0;
      muldiv_cnt  = 6'd0;
      if (!reset) begin
         forward_a   = fa;
         forward_b   = fb;
         muldiv_busy = (state_q == BUSY);
         hilo_write  = (state_q == DONE);
         muldiv_cnt  = cnt_q;
         if (branch_taken) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
         end else if (md_stall) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            flush_exmem = 1'b1;
         end else if (lu) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            flush_idex  = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: directed scenarios
// followed by random traffic against a cycle-count model.
module tb_ex_hazard_ctrl;

   localparam int MUL_N = 4;
   localparam int DIV_N = 32;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd;
   logic       ex_mem_read, ex_muldiv_start, ex_muldiv_is_div;
   logic       mem_reg_write, wb_reg_write, branch_taken;
   logic [1:0] forward_a, forward_b;
   logic       stall_pc, stall_ifid, stall_idex;
   logic       flush_ifid, flush_idex, flush_exmem;
   logic       muldiv_busy, hilo_write;
   logic [5:0] muldiv_cnt;

   ex_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt),
      .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_mem_read(ex_mem_read),
      .ex_muldiv_start(ex_muldiv_start),
      .ex_muldiv_is_div(ex_muldiv_is_div),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .branch_taken(branch_taken),
      .forward_a(forward_a), .forward_b(forward_b),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .stall_idex(stall_idex),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .flush_exmem(flush_exmem),
      .muldiv_busy(muldiv_busy), .hilo_write(hilo_write),
      .muldiv_cnt(muldiv_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [17:0] v;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   stim_done = 0;

   // model: operation bookkeeping in absolute cycle numbers
   int   cyc = 0;
   bit   op_on = 0;
   int   op_start = 0;
   int   op_end = 0;
   string cur_tag = "init";

   function automatic logic [1:0] fsel(input logic [4:0] s);
      if (mem_reg_write && mem_rd != 0 && mem_rd == s) return 2'b10;
      if (wb_reg_write && wb_rd != 0 && wb_rd == s) return 2'b01;
      return 2'b00;
   endfunction

   task automatic push_expect();
      exp_t e;
      logic [1:0] fa, fb;
      bit lu, busy, done, start, stall;
      bit s_pc, s_if, s_ix, f_if, f_ix, f_em;
      int cnt;
      e.tag = cur_tag;
      if (reset) begin
         e.v = '0;
         op_on = 0;
      end else begin
         fa = fsel(ex_rs);
         fb = fsel(ex_rt);
         lu = ex_mem_read && ex_rt != 0 &&
              (ex_rt == id_rs || ex_rt == id_rt);
         done  = op_on && cyc == op_end;
         busy  = op_on && cyc > op_start && cyc < op_end;
         start = !op_on && ex_muldiv_start;
         stall = busy || start;
         cnt   = busy ? op_end - cyc : 0;
         {s_pc, s_if, s_ix, f_if, f_ix, f_em} = '0;
         if (branch_taken) {f_if, f_ix, f_em} = 3'b111;
         else if (stall) {s_pc, s_if, s_ix, f_em} = 4'b1111;
         else if (lu) {s_pc, s_if, f_ix} = 3'b111;
         e.v = {fa, fb, s_pc, s_if, s_ix, f_if, f_ix, f_em,
                busy, done, 6'(cnt)};
         if (done) op_on = 0;
         if (busy && branch_taken) op_on = 0;
         if (start && !branch_taken) begin
            op_on = 1;
            op_start = cyc;
            op_end = cyc + (ex_muldiv_is_div ? DIV_N : MUL_N);
         end
      end
      cyc++;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      reset = 0;
      {id_rs, id_rt, ex_rs, ex_rt, mem_rd, wb_rd} = '0;
      {ex_mem_read, ex_muldiv_start, ex_muldiv_is_div} = '0;
      {mem_reg_write, wb_reg_write, branch_taken} = '0;
   endtask

   // run one cycle with the current inputs
   task automatic cyc1(input string t);
      cur_tag = t;
      push_expect();
      tick();
   endtask

   // monitor: compare DUT outputs mid-cycle against queue head
   initial begin
      exp_t e;
      logic [17:0] act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {forward_a, forward_b, stall_pc, stall_ifid,
                   stall_idex, flush_ifid, flush_idex,
                   flush_exmem, muldiv_busy, hilo_write,
                   muldiv_cnt};
            n_cmp++;
            if (act !== e.v) begin
               n_bad++;
               $display("FAIL %s: got %05h expected %05h",
                        e.tag, act, e.v);
            end
         end
      end
   end

   initial begin
      clr();
      tick();
      reset = 1;
      ex_muldiv_start = 1; branch_taken = 1;
      ex_rs = 5; mem_rd = 5; mem_reg_write = 1;
      repeat (3) cyc1("reset");
      clr();
      // forwarding priority
      ex_rs = 5; mem_rd = 5; mem_reg_write = 1;
      wb_rd = 5; wb_reg_write = 1;
      cyc1("fwd_mem");
      mem_reg_write = 0;
      cyc1("fwd_wb");
      ex_rs = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1;
      cyc1("fwd_r0");
      ex_rt = 7; mem_rd = 7; wb_rd = 7;
      cyc1("fwd_b_mem");
      clr();
      // load-use
      ex_mem_read = 1; ex_rt = 8; id_rt = 8;
      cyc1("lu");
      clr();
      cyc1("lu_after");
      ex_mem_read = 1; ex_rt = 0; id_rt = 0;
      cyc1("lu_r0");
      clr();
      // multiply: held in ID/EX through DONE
      ex_muldiv_start = 1;
      repeat (MUL_N + 1) cyc1("mul");
      clr();
      repeat (2) cyc1("mul_idle");
      // divide
      ex_muldiv_start = 1; ex_muldiv_is_div = 1;
      repeat (DIV_N + 1) cyc1("div");
      clr();
      cyc1("div_idle");
      // branch squash at cnt==2
      ex_muldiv_start = 1;
      repeat (2) cyc1("sq_run");
      branch_taken = 1;
      cyc1("sq_branch");
      clr();
      repeat (4) cyc1("sq_after");
      // reset mid-divide at cnt==10, with load-use present
      ex_muldiv_start = 1; ex_muldiv_is_div = 1;
      repeat (DIV_N - 10) cyc1("rst_run");
      reset = 1; ex_mem_read = 1; ex_rt = 3; id_rs = 3;
      repeat (2) cyc1("rst_mid");
      clr();
      repeat (3) cyc1("rst_after");
      // load-use during BUSY: muldiv pattern only
      ex_muldiv_start = 1;
      cyc1("lu_busy_start");
      ex_mem_read = 1; ex_rt = 4; id_rt = 4;
      repeat (MUL_N) cyc1("lu_busy");
      clr();
      cyc1("lu_busy_after");
      // random traffic
      repeat (3000) begin
         reset = ($urandom_range(0, 99) == 0);
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ex_rs = 5'($urandom_range(0, 3));
         ex_rt = 5'($urandom_range(0, 3));
         mem_rd = 5'($urandom_range(0, 3));
         wb_rd = 5'($urandom_range(0, 3));
         ex_mem_read = ($urandom_range(0, 2) == 0);
         ex_muldiv_start = ($urandom_range(0, 5) == 0);
         ex_muldiv_is_div = ($urandom_range(0, 3) == 0);
         mem_reg_write = 1'($urandom);
         wb_reg_write = 1'($urandom);
         branch_taken = ($urandom_range(0, 15) == 0);
         cyc1("rand");
      end
      clr();
      repeat (4) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0",
                  exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
